// File: rtl/ddr_rw_arbiter.sv
// Arbitrates DDR3 write bursts (drain write FIFO) against read bursts (refill read FIFO).
// Ties alternate between the two sides; each side walks its own address region.
module ddr_rw_arbiter #(
  parameter int ADDR_W        = 30,
  parameter int BURST_WORDS   = 64,
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int ADDR_INC      = 128,
  parameter int WR_BASE       = 0,
  parameter int WR_END        = 2048,
  parameter int RD_BASE       = 0,
  parameter int RD_END        = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic              rd_mem_enable,
  input  logic [10:0]       wr_fifo_cnt,
  input  logic [10:0]       rd_fifo_cnt,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              busy
);

  typedef enum logic [1:0] {WAIT_CALIB, IDLE, WR, RD} state_t;

  localparam logic [11:0] WR_THRESH = 12'(BURST_WORDS);
  localparam logic [11:0] RD_LIMIT  = 12'(RD_FIFO_DEPTH - BURST_WORDS);

  state_t            state;
  logic              last_wr;
  logic              wr_elig;
  logic              rd_elig;
  logic              grant_wr;
  logic              grant_rd;
  logic [ADDR_W-1:0] wr_addr_inc;
  logic [ADDR_W-1:0] rd_addr_inc;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [ADDR_W-1:0] rd_addr_next;

  assign wr_elig = {1'b0, wr_fifo_cnt} >= WR_THRESH;
  assign rd_elig = rd_mem_enable && ({1'b0, rd_fifo_cnt} <= RD_LIMIT);

  // On a tie the side that did not win last time gets the burst.
  assign grant_wr = wr_elig && (!rd_elig || !last_wr);
  assign grant_rd = rd_elig && !grant_wr;

  assign wr_addr_inc  = wr_addr + ADDR_W'(ADDR_INC);
  assign rd_addr_inc  = rd_addr + ADDR_W'(ADDR_INC);
  assign wr_addr_next = (wr_addr_inc == ADDR_W'(WR_END)) ? ADDR_W'(WR_BASE) : wr_addr_inc;
  assign rd_addr_next = (rd_addr_inc == ADDR_W'(RD_END)) ? ADDR_W'(RD_BASE) : rd_addr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_CALIB;
      wr_req  <= 1'b0;
      rd_req  <= 1'b0;
      busy    <= 1'b0;
      wr_addr <= ADDR_W'(WR_BASE);
      rd_addr <= ADDR_W'(RD_BASE);
      last_wr <= 1'b0;
    end else begin
      case (state)
        WAIT_CALIB: begin
          if (calib_done) state <= IDLE;
        end
        IDLE: begin
          if (!rd_mem_enable) rd_addr <= ADDR_W'(RD_BASE);
          if (!calib_done) begin
            state <= WAIT_CALIB;
          end else if (grant_wr) begin
            state   <= WR;
            wr_req  <= 1'b1;
            busy    <= 1'b1;
            last_wr <= 1'b1;
          end else if (grant_rd) begin
            state   <= RD;
            rd_req  <= 1'b1;
            busy    <= 1'b1;
            last_wr <= 1'b0;
          end
        end
        WR: begin
          if (wr_done) begin
            state   <= IDLE;
            wr_req  <= 1'b0;
            busy    <= 1'b0;
            wr_addr <= wr_addr_next;
          end
        end
        RD: begin
          if (rd_done) begin
            state   <= IDLE;
            rd_req  <= 1'b0;
            busy    <= 1'b0;
            rd_addr <= rd_addr_next;
          end
        end
        default: state <= WAIT_CALIB;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Self-checking bench for ddr_rw_arbiter: directed vector table, corner-case
// sequences and a randomized run against a burst-counting reference model.
module tb_ddr_rw_arbiter;

  localparam int ADDR_W  = 30;
  localparam int INC     = 128;
  localparam int NBURSTS = 2048 / INC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              calib_done = 1'b0;
  logic              rd_mem_enable = 1'b0;
  logic [10:0]       wr_fifo_cnt = '0;
  logic [10:0]       rd_fifo_cnt = '0;
  logic              wr_done = 1'b0;
  logic              rd_done = 1'b0;
  logic              wr_req;
  logic              rd_req;
  logic              busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  int checks = 0;
  int failures = 0;

  ddr_rw_arbiter dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .rd_mem_enable(rd_mem_enable),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit calib;
    bit en;
    int wr_cnt;
    int rd_cnt;
    bit exp_wr;
    bit exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    calib_done = 1'b0; rd_mem_enable = 1'b0;
    wr_fifo_cnt = '0; rd_fifo_cnt = '0; wr_done = 1'b0; rd_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_wr_req", 32'(wr_req), 0);
    checkOutput("reset_rd_req", 32'(rd_req), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 0);
    checkOutput("reset_rd_addr", 32'(rd_addr), 0);
  endtask

  // Called at a negedge; waits (bounded) for either request.
  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_req || rd_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("req_timeout", 0, 1);
  endtask

  task automatic pulseDone(input bit is_wr);
    if (is_wr) wr_done = 1'b1; else rd_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    calib_done    = v.calib;
    rd_mem_enable = v.en;
    wr_fifo_cnt   = 11'(v.wr_cnt);
    rd_fifo_cnt   = 11'(v.rd_cnt);
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("vec%0d_wr_req", idx), 32'(wr_req), 32'(v.exp_wr));
    checkOutput($sformatf("vec%0d_rd_req", idx), 32'(rd_req), 32'(v.exp_rd));
    checkOutput($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.exp_wr | v.exp_rd));
    wr_fifo_cnt = '0;
    rd_fifo_cnt = 11'd1023;
    wr_done = 1'b1; rd_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0;
  endtask

  // Reference model state: burst counts rather than addresses.
  int  m_ready, m_active, m_last_wr, m_wr_n, m_rd_n;

  task automatic modelStep(input bit c, input bit en, input int wc, input int rc,
                           input bit wd, input bit rdn);
    bit we, re;
    if (!m_ready) begin
      if (c) m_ready = 1;
    end else if (m_active == 0) begin
      if (!en) m_rd_n = 0;
      we = (wc >= 64);
      re = en && (rc <= 1024 - 64);
      if (!c) m_ready = 0;
      else if (we && re) begin
        m_active  = m_last_wr ? 2 : 1;
        m_last_wr = (m_active == 1);
      end else if (we) begin
        m_active = 1; m_last_wr = 1;
      end else if (re) begin
        m_active = 2; m_last_wr = 0;
      end
    end else if (m_active == 1 && wd) begin
      m_active = 0; m_wr_n++;
    end else if (m_active == 2 && rdn) begin
      m_active = 0; m_rd_n++;
    end
  endtask

  initial begin
    bit ok;
    bit exp_side_wr [4] = '{1, 0, 1, 0};
    int exp_addr [4] = '{0, 0, 128, 128};
    int wc, rc;

    vecs[0] = '{1, 1, 63, 961, 0, 0};
    vecs[1] = '{1, 1, 0, 961, 0, 0};
    vecs[2] = '{1, 1, 0, 960, 0, 1};
    vecs[3] = '{1, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 1, 64, 0, 1, 0};
    vecs[5] = '{1, 1, 64, 0, 0, 1};
    vecs[6] = '{1, 0, 2047, 0, 1, 0};
    vecs[7] = '{1, 1, 63, 0, 0, 1};
    vecs[8] = '{0, 1, 100, 0, 0, 0};

    // Vector table from IDLE
    doReset();
    calib_done = 1'b1; rd_mem_enable = 1'b1; rd_fifo_cnt = 11'd1023;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // No request before calibration, then within two cycles of calib_done
    doReset();
    wr_fifo_cnt = 11'd100;
    repeat (5) @(negedge clk);
    checkOutput("precal_wr_req", 32'(wr_req), 0);
    calib_done = 1'b1;
    @(negedge clk);
    checkOutput("cal_1cyc_wr_req", 32'(wr_req), 0);
    @(negedge clk);
    checkOutput("cal_2cyc_wr_req", 32'(wr_req), 1);
    checkOutput("cal_wr_addr", 32'(wr_addr), 0);
    pulseDone(1'b1);

    // Alternation W,R,W,R and rd_addr reload
    doReset();
    calib_done = 1'b1; wr_fifo_cnt = 11'd64; rd_mem_enable = 1'b1; rd_fifo_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      waitReq(ok);
      if (!ok) break;
      checkOutput($sformatf("alt%0d_both", i), 32'(wr_req & rd_req), 0);
      checkOutput($sformatf("alt%0d_is_wr", i), 32'(wr_req), 32'(exp_side_wr[i]));
      checkOutput($sformatf("alt%0d_addr", i), wr_req ? 32'(wr_addr) : 32'(rd_addr), 32'(exp_addr[i]));
      pulseDone(wr_req);
    end
    rd_mem_enable = 1'b0;
    @(negedge clk);
    checkOutput("rd_addr_reload", 32'(rd_addr), 0);

    // Write address walk and wrap, with an IDLE gap after each burst
    doReset();
    calib_done = 1'b1; wr_fifo_cnt = 11'd64;
    for (int i = 0; i <= NBURSTS; i++) begin
      waitReq(ok);
      if (!ok) break;
      checkOutput($sformatf("walk%0d_addr", i), 32'(wr_addr), 32'((i % NBURSTS) * INC));
      pulseDone(1'b1);
      checkOutput($sformatf("walk%0d_gap", i), 32'(wr_req), 0);
    end

    // Foreign done ignored, then asynchronous reset mid-burst
    doReset();
    calib_done = 1'b1; wr_fifo_cnt = 11'd64;
    for (int i = 0; i < 2; i++) begin
      waitReq(ok);
      pulseDone(1'b1);
    end
    waitReq(ok);
    checkOutput("mid_wr_addr", 32'(wr_addr), 256);
    pulseDone(1'b0);
    checkOutput("rd_done_ignored_req", 32'(wr_req), 1);
    checkOutput("rd_done_ignored_busy", 32'(busy), 1);
    checkOutput("rd_done_ignored_addr", 32'(wr_addr), 256);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_wr_req", 32'(wr_req), 0);
    checkOutput("async_rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("async_rst_busy", 32'(busy), 0);

    // Randomized run against the reference model
    doReset();
    m_ready = 0; m_active = 0; m_last_wr = 0; m_wr_n = 0; m_rd_n = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      checkOutput("rnd_wr_req", 32'(wr_req), 32'(m_active == 1));
      checkOutput("rnd_rd_req", 32'(rd_req), 32'(m_active == 2));
      checkOutput("rnd_busy", 32'(busy), 32'(m_active != 0));
      checkOutput("rnd_wr_addr", 32'(wr_addr), 32'((m_wr_n % NBURSTS) * INC));
      checkOutput("rnd_rd_addr", 32'(rd_addr), 32'((m_rd_n % NBURSTS) * INC));
      case ($urandom_range(0, 3))
        0: wc = 63;
        1: wc = 64;
        default: wc = $urandom_range(0, 2047);
      endcase
      case ($urandom_range(0, 3))
        0: rc = 960;
        1: rc = 961;
        default: rc = $urandom_range(0, 2047);
      endcase
      calib_done    = ($urandom_range(0, 19) != 0);
      rd_mem_enable = ($urandom_range(0, 3) != 0);
      wr_fifo_cnt   = 11'(wc);
      rd_fifo_cnt   = 11'(rc);
      wr_done       = ($urandom_range(0, 2) == 0);
      rd_done       = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      modelStep(calib_done, rd_mem_enable, wc, rc, wr_done, rd_done);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_rw_arbiter.md
DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30: DDR3 byte-address width.
REQ-002 SHALL have parameter BURST_WORDS, default 64: FIFO words moved per burst.
REQ-003 SHALL have parameter RD_FIFO_DEPTH, default 1024: read FIFO depth in words.
REQ-004 SHALL have parameter ADDR_INC, default 128: byte-address step per burst (64 words x 2 bytes).
REQ-005 SHALL have parameters WR_BASE/WR_END and RD_BASE/RD_END, defaults 0 and 2048: region bounds, END exclusive.
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port calib_done, input, 1: DDR3 initialisation complete.
REQ-009 SHALL have port rd_mem_enable, input, 1: user permission to read DDR3.
REQ-010 SHALL have port wr_fifo_cnt, input, 11: words waiting in the write FIFO.
REQ-011 SHALL have port rd_fifo_cnt, input, 11: words held in the read FIFO.
REQ-012 SHALL have port wr_req, output, 1: write-burst request to the AXI master.
REQ-013 SHALL have port wr_addr, output, ADDR_W: write-burst start address.
REQ-014 SHALL have port wr_done, input, 1: one-cycle pulse, write burst finished.
REQ-015 SHALL have port rd_req, output, 1: read-burst request to the AXI master.
REQ-016 SHALL have port rd_addr, output, ADDR_W: read-burst start address.
REQ-017 SHALL have port rd_done, input, 1: one-cycle pulse, read burst finished.
REQ-018 SHALL have port busy, output, 1: high whenever the state is not IDLE or WAIT_CALIB.

Function
REQ-019 SHALL implement states WAIT_CALIB, IDLE, WR, RD.
REQ-020 SHALL move WAIT_CALIB->IDLE on the first clock with calib_done=1; IDLE->WAIT_CALIB if calib_done=0 in IDLE.
REQ-021 SHALL treat write as eligible in IDLE when wr_fifo_cnt >= BURST_WORDS.
REQ-022 SHALL treat read as eligible in IDLE when rd_mem_enable=1 and rd_fifo_cnt <= RD_FIFO_DEPTH-BURST_WORDS.
REQ-023 SHALL grant the only eligible side; when both are eligible, grant the side not granted last, with write winning the first tie after reset.
REQ-024 SHALL register the grant: the state becomes WR/RD and wr_req/rd_req rises on the clock edge that samples eligibility (1-cycle latency from eligible inputs).
REQ-025 SHALL hold the req output high and its address stable until the matching done pulse is sampled; on that edge req falls, the address advances and the state returns to IDLE.
REQ-026 SHALL leave at least one IDLE cycle between consecutive bursts.
REQ-027 SHALL never assert wr_req and rd_req together.
REQ-028 SHALL advance addresses by ADDR_INC; an address equal to END after advancing SHALL wrap to BASE on the same edge.
REQ-029 SHALL ignore wr_done outside WR and rd_done outside RD.
REQ-030 SHALL, in WR/RD, finish the current burst regardless of calib_done or rd_mem_enable.
REQ-031 SHALL reload rd_addr to RD_BASE on every IDLE clock with rd_mem_enable=0.

Reset
REQ-032 SHALL, while rst_n=0, force state WAIT_CALIB, wr_req=0, rd_req=0, busy=0, wr_addr=WR_BASE, rd_addr=RD_BASE, tie preference to write, asynchronously and mid-burst included.

Verification
REQ-033 SHALL verify: calib_done=0 and wr_fifo_cnt=100 -> wr_req stays 0; calib_done rises -> wr_req=1 with wr_addr=0 within 2 cycles.
REQ-034 SHALL verify: wr_fifo_cnt=64, rd_mem_enable=1, rd_fifo_cnt=0 held -> bursts alternate W,R,W,R, with addresses 0,0,128,128.
REQ-035 SHALL verify: 16 write bursts -> wr_addr sequence 0..1920 in steps of 128, then wraps to 0.
REQ-036 SHALL verify: rd_fifo_cnt=961 -> no rd_req; rd_fifo_cnt=960 -> rd_req asserts; rd_mem_enable=0 in IDLE -> rd_addr=0.
REQ-037 SHALL verify: rst_n low during WR with wr_addr=256 -> wr_req=0 immediately and wr_addr=0; a rd_done pulse during WR leaves the state unchanged.
